// File: rtl/bus_arbiter_if.sv
// One master's request/grant/read-return port into the two-master bus arbiter.
// The master modport drives requests; the arbiter side uses the slave modport.
interface bus_arbiter_if #(
    parameter int AW = 64,
    parameter int DW = 64
);
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          gnt;
    logic          rvalid;
    logic [DW-1:0] rdata;

    modport master (
        output req, we, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin arbiter with a bounded burst allowance between two bus masters.
// The winning request is registered onto the bus; read data returns two cycles after grant.
module bus_arbiter #(
    parameter int AW        = 64,
    parameter int DW        = 64,
    parameter int MAX_BURST = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    bus_arbiter_if.slave  m0_if,
    bus_arbiter_if.slave  m1_if,
    output logic [AW-1:0] bus_address_o,
    output logic [DW-1:0] bus_write_data_o,
    output logic          bus_write_enable_o,
    output logic          bus_read_enable_o,
    input  logic [DW-1:0] bus_read_data_i
);
    localparam int             CW        = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0]  BURST_MAX = CW'(MAX_BURST);

    logic          prio_q,      prio_d;
    logic          owner_vld_q, owner_vld_d;
    logic          owner_q,     owner_d;
    logic [CW-1:0] burst_cnt_q, burst_cnt_d;
    logic [AW-1:0] bus_addr_q,  bus_addr_d;
    logic [DW-1:0] bus_wdata_q, bus_wdata_d;
    logic          bus_we_q,    bus_we_d;
    logic          bus_re_q,    bus_re_d;
    logic [1:0]    pend_vld_q,  pend_vld_d;
    logic [1:0]    pend_id_q,   pend_id_d;

    logic          gnt_any;
    logic          gnt_id;
    logic          sel_we;
    logic          rv0;
    logic          rv1;

    // gnt_id is the winning master; only meaningful when gnt_any is high
    always_comb begin
        gnt_any = m0_if.req | m1_if.req;
        gnt_id  = m1_if.req;
        if (m0_if.req && m1_if.req) begin
            if (!owner_vld_q) begin
                gnt_id = prio_q;
            end else if (burst_cnt_q < BURST_MAX) begin
                gnt_id = owner_q;
            end else begin
                gnt_id = ~owner_q;
            end
        end
    end

    assign m0_if.gnt = gnt_any & ~gnt_id;
    assign m1_if.gnt = gnt_any & gnt_id;
    assign sel_we    = gnt_id ? m1_if.we : m0_if.we;

    always_comb begin
        prio_d      = prio_q;
        owner_vld_d = owner_vld_q;
        owner_d     = owner_q;
        burst_cnt_d = burst_cnt_q;
        bus_addr_d  = '0;
        bus_wdata_d = '0;
        bus_we_d    = 1'b0;
        bus_re_d    = 1'b0;
        pend_vld_d  = {pend_vld_q[0], 1'b0};
        pend_id_d   = {pend_id_q[0], gnt_id};
        if (gnt_any) begin
            bus_addr_d    = gnt_id ? m1_if.addr  : m0_if.addr;
            bus_wdata_d   = gnt_id ? m1_if.wdata : m0_if.wdata;
            bus_we_d      = sel_we;
            bus_re_d      = ~sel_we;
            pend_vld_d[0] = ~sel_we;
            if (owner_vld_q && (owner_q == gnt_id)) begin
                if (burst_cnt_q < BURST_MAX) begin
                    burst_cnt_d = burst_cnt_q + 1'b1;
                end
            end else begin
                owner_vld_d = 1'b1;
                owner_d     = gnt_id;
                burst_cnt_d = CW'(1);
                prio_d      = ~gnt_id;
            end
        end else begin
            // an idle cycle ends the burst; the owner keeps its claim to the next tie
            burst_cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prio_q      <= 1'b0;
            owner_vld_q <= 1'b0;
            owner_q     <= 1'b0;
            burst_cnt_q <= '0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_we_q    <= 1'b0;
            bus_re_q    <= 1'b0;
            pend_vld_q  <= '0;
            pend_id_q   <= '0;
        end else begin
            prio_q      <= prio_d;
            owner_vld_q <= owner_vld_d;
            owner_q     <= owner_d;
            burst_cnt_q <= burst_cnt_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_we_q    <= bus_we_d;
            bus_re_q    <= bus_re_d;
            pend_vld_q  <= pend_vld_d;
            pend_id_q   <= pend_id_d;
        end
    end

    assign bus_address_o      = bus_addr_q;
    assign bus_write_data_o   = bus_wdata_q;
    assign bus_write_enable_o = bus_we_q;
    assign bus_read_enable_o  = bus_re_q;

    assign rv0          = pend_vld_q[1] & ~pend_id_q[1];
    assign rv1          = pend_vld_q[1] &  pend_id_q[1];
    assign m0_if.rvalid = rv0;
    assign m1_if.rvalid = rv1;
    assign m0_if.rdata  = rv0 ? bus_read_data_i : '0;
    assign m1_if.rdata  = rv1 ? bus_read_data_i : '0;
endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Two-master arbiter that shares the single system bus (RAM, keyboard and UART windows) between the `riscv64` core and a second bus master such as a loader or DMA engine. It grants at most one transfer per cycle using round-robin with a bounded burst allowance. It registers the winning request onto the bus and routes read data back to the issuing master with a fixed latency.

## Interface
- `AW`, default 64: address width.
- `DW`, default 64: data width.
- `MAX_BURST`, default 4: maximum number of consecutive grants to one master while the other is requesting (minimum 1).

- `clk`, input, 1: system clock; all state updates on the rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `m0_req`, input, 1: master 0 (core) request. Held with `m0_we`, `m0_addr`, `m0_wdata` stable until `m0_gnt`.
- `m0_we`, input, 1: 1 means write, 0 means read.
- `m0_addr`, input, AW: transfer address.
- `m0_wdata`, input, DW: write data.
- `m0_gnt`, output, 1: combinational grant; the request is accepted on this clock edge.
- `m0_rvalid`, output, 1: one-cycle pulse; `m0_rdata` is valid.
- `m0_rdata`, output, DW: read data.
- `m1_req`, `m1_we`, `m1_addr`, `m1_wdata`, `m1_gnt`, `m1_rvalid`, `m1_rdata`: identical to master 0, for master 1.
- `bus_address`, output, AW: registered bus address.
- `bus_write_data`, output, DW: registered write data.
- `bus_write_enable`, output, 1: registered; high for exactly one cycle per granted write.
- `bus_read_enable`, output, 1: registered; high for exactly one cycle per granted read.
- `bus_read_data`, input, DW: slave read data, valid the cycle after `bus_read_enable`.

## Operation
- **Internal state:**
  - `prio`: the master that wins a tie.
  - `owner`: the last granted master.
  - `burst_cnt`: counts 1..MAX_BURST.
  - `rd_pend`: 2-stage shift of {valid, master id} for outstanding reads.
- **Grant selection (combinational, each cycle):**
  - No request: no grant.
  - One master requesting: that master is granted.
  - Both requesting: the `owner` is granted if `burst_cnt < MAX_BURST`; otherwise the other master is granted. If no owner has been established since reset, `prio` decides.
  - `m0_gnt` and `m1_gnt` are never high together.
- **On a grant edge:**
  - Bus outputs load the granted master's address, data and direction. `bus_write_enable = we`, `bus_read_enable = ~we`.
  - If the grant goes to the same master as `owner`, `burst_cnt` increments, saturating at MAX_BURST. Otherwise `owner` takes the new master, `burst_cnt` becomes 1, and `prio` becomes the other master.
- **No grant edge:**
  - `bus_write_enable` and `bus_read_enable` return to 0.
  - `bus_address` and `bus_write_data` return to 0.
  - `burst_cnt` resets to 0, so the next grant starts a fresh burst.
- **Read return:**
  - A granted read pushes {1, id} into `rd_pend`.
  - When the stage-2 entry is valid, `mX_rvalid` for that id pulses and `mX_rdata = bus_read_data`, routed combinationally.
  - The non-addressed master's `rdata` is 0.
- Writes produce no `rvalid`.

## Timing
- Cycle N: `req` high and `gnt` high (same cycle).
- Cycle N+1: bus signals reflect the transfer.
- Cycle N+2: slave data is valid and `mX_rvalid` is high. Read latency is 2 cycles from grant.
- Throughput is one transfer per cycle. Back-to-back reads from different masters return in grant order without gaps.
- **Reset (asynchronous):**
  - All bus outputs are 0.
  - `rd_pend` is cleared and `rvalid` is 0; in-flight reads are dropped.
  - `owner` is none, `prio = 0`, `burst_cnt = 0`.
  - `gnt` still follows `req` combinationally, but no grant takes effect while reset is high.
- Simultaneous first requests after reset: master 0 wins.
- A request withdrawn before grant is legal and leaves no side effects.

## Test plan
- **Single read:** `m0_req=1`, `we=0`, `addr=0x8000_0000`; slave returns `0x1234` at N+2. Required: `m0_gnt` at N, `bus_read_enable=1` and `bus_address=0x8000_0000` at N+1 only, `m0_rvalid=1` and `m0_rdata=0x1234` at N+2, `m1_rvalid=0`.
- **Tie after reset:** both masters request a single write. Required: m0 granted at N, m1 at N+1, `bus_write_enable` high at N+1 and N+2 with the respective data.
- **Burst limit:** both request continuously, MAX_BURST=4. Required grant sequence m0,m0,m0,m0,m1,m1,m1,m1,m0.
- **Burst saturation:** m1 requests alone for 10 cycles, then m0 joins. Required: m1 granted 10 times, then m0 granted on the next cycle.
- **Interleaved reads:** m0 read at N, m1 read at N+1; slave data 0xA then 0xB. Required: `m0_rvalid` at N+2 with 0xA, `m1_rvalid` at N+3 with 0xB.
- **Reset mid-read:** assert `reset` at N+1 after a granted read. Required: all outputs 0 immediately, no `rvalid` at N+2, and normal operation on the first request after release.
